bcd3_to_byte_seq: RTL and testbench

Sequential BCD-to-binary converter: accepts three BCD digits (hundreds, tens, units) with a start strobe and returns the equivalent 8-bit binary byte. It is the inverse of the display path's byte-to-BCD conversion and sits between keypad/switch digit entry and the datapath that consumes byte values. Conversion uses the reverse double-dabble algorithm: shift right, then apply a per-digit correction, for a fixed number of steps. It flags invalid digits and values above 255.

---
 rtl/bcd3_to_byte_seq_pkg.sv | 22 ++
 rtl/bcd3_to_byte_seq_corrector.sv | 12 +
 rtl/bcd3_to_byte_seq.sv | 100 ++++++++++
 tb/tb_bcd3_to_byte_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd3_to_byte_seq_pkg.sv
// Shared constants and state type for the three-digit BCD to byte converter.
package bcd3_to_byte_seq_pkg;

  localparam int unsigned N_DIGITOS = 3;
  localparam int unsigned ANCHO_BCD = 12;
  localparam int unsigned ANCHO_BIN = 10;
  localparam int unsigned PASOS     = 10;

  localparam logic [ANCHO_BIN-1:0] MAX_BYTE    = 10'd255;
  localparam logic [3:0]           ULTIMO_PASO = 4'(PASOS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    INVAL
  } estado_t;

  function automatic logic digito_invalido(input logic [3:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/bcd3_to_byte_seq_corrector.sv
// Per-digit correction of the reverse double-dabble step: d >= 8 ? d - 3 : d.
module bcd_digito_corrector (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd8) q = d - 4'd3;
  end

endmodule

// File: rtl/bcd3_to_byte_seq.sv
// Sequential three-digit BCD to byte converter using reverse double-dabble,
// with invalid-digit and >255 detection.
module bcd3_to_byte_seq
  import bcd3_to_byte_seq_pkg::*;
#(
  parameter bit SATURAR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] centena,
  input  logic [3:0] decena,
  input  logic [3:0] unidad,
  output logic [7:0] salida,
  output logic       listo,
  output logic       ocupado,
  output logic       error,
  output logic       desborde
);

  estado_t                estado;
  logic [ANCHO_BCD-1:0]   bcd;
  logic [ANCHO_BIN-1:0]   bin;
  logic [3:0]             cnt;

  logic [ANCHO_BCD+ANCHO_BIN-1:0] desplazado;
  logic [ANCHO_BCD-1:0]           bcd_corr;
  logic [ANCHO_BIN-1:0]           bin_sig;
  logic                           entrada_invalida;

  assign desplazado = {bcd, bin} >> 1;
  assign bin_sig    = desplazado[ANCHO_BIN-1:0];

  assign entrada_invalida = digito_invalido(centena) | digito_invalido(decena)
                          | digito_invalido(unidad);

  for (genvar i = 0; i < N_DIGITOS; i++) begin : g_corr
    bcd_digito_corrector u_corr (
      .d (desplazado[ANCHO_BIN + 4*i +: 4]),
      .q (bcd_corr[4*i +: 4])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado   <= IDLE;
      bcd      <= '0;
      bin      <= '0;
      cnt      <= '0;
      salida   <= '0;
      listo    <= 1'b0;
      ocupado  <= 1'b0;
      error    <= 1'b0;
      desborde <= 1'b0;
    end else begin
      listo <= 1'b0;
      case (estado)
        IDLE: begin
          if (start) begin
            bcd      <= {centena, decena, unidad};
            bin      <= '0;
            cnt      <= '0;
            error    <= 1'b0;
            desborde <= 1'b0;
            ocupado  <= 1'b1;
            estado   <= entrada_invalida ? INVAL : CONV;
          end
        end
        INVAL: begin
          salida   <= '0;
          error    <= 1'b1;
          desborde <= 1'b0;
          listo    <= 1'b1;
          ocupado  <= 1'b0;
          estado   <= IDLE;
        end
        CONV: begin
          bcd <= bcd_corr;
          bin <= bin_sig;
          cnt <= cnt + 4'd1;
          // The last step's result is taken straight from the shifted value,
          // so the byte is valid on the same edge as the tenth shift.
          if (cnt == ULTIMO_PASO) begin
            if (bin_sig > MAX_BYTE) begin
              desborde <= 1'b1;
              salida   <= SATURAR ? 8'hFF : bin_sig[7:0];
            end else begin
              salida   <= bin_sig[7:0];
            end
            listo   <= 1'b1;
            ocupado <= 1'b0;
            estado  <= IDLE;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd3_to_byte_seq.sv
// Self-checking bench: saturating and wrapping instances driven in parallel
// and compared against an arithmetic reference model.
module tb_bcd3_to_byte_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] centena, decena, unidad;

  logic [7:0] salida_s, salida_n;
  logic       listo_s, listo_n, ocupado_s, ocupado_n;
  logic       error_s, error_n, desborde_s, desborde_n;

  int comparados = 0;
  int fallos     = 0;

  always #5 clk = ~clk;

  bcd3_to_byte_seq #(.SATURAR(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .start(start),
    .centena(centena), .decena(decena), .unidad(unidad),
    .salida(salida_s), .listo(listo_s), .ocupado(ocupado_s),
    .error(error_s), .desborde(desborde_s)
  );

  bcd3_to_byte_seq #(.SATURAR(1'b0)) dut_nosat (
    .clk(clk), .rst(rst), .start(start),
    .centena(centena), .decena(decena), .unidad(unidad),
    .salida(salida_n), .listo(listo_n), .ocupado(ocupado_n),
    .error(error_n), .desborde(desborde_n)
  );

  // Reference: decimal value from the digits, then the overflow policy.
  function automatic void modelo(input int c, input int d, input int u, input bit sat,
                                 output logic [7:0] s, output logic e, output logic o);
    int v;
    if (c > 9 || d > 9 || u > 9) begin
      s = 8'h00; e = 1'b1; o = 1'b0;
    end else begin
      v = 100*c + 10*d + u;
      e = 1'b0;
      o = (v > 255);
      s = (o && sat) ? 8'hFF : 8'(v);
    end
  endfunction

  // Drives a start pulse; returns #1 after the accepting edge with digits scrambled.
  task automatic lanzar(input int c, input int d, input int u);
    centena = 4'(c); decena = 4'(d); unidad = 4'(u); start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    centena = 4'($urandom); decena = 4'($urandom); unidad = 4'($urandom);
  endtask

  // Edges until listo (lat = -1 if it never comes); counts cycles busy was low before it.
  task automatic esperar(output int lat, output int sin_ocupado);
    lat = -1; sin_ocupado = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (listo_s) begin lat = k; break; end
      if (!ocupado_s) sin_ocupado++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; centena = '0; decena = '0; unidad = '0;
    repeat (2) @(posedge clk); #1;
    comparados++;
    if ({salida_s, listo_s, ocupado_s, error_s, desborde_s,
         salida_n, listo_n, ocupado_n, error_n, desborde_n} !== 24'h0) begin
      fallos++;
      $display("FAIL reset: outputs %h want 0", {salida_s, listo_s, ocupado_s, error_s, desborde_s,
               salida_n, listo_n, ocupado_n, error_n, desborde_n});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_255();
    int lat, sin_oc;
    lanzar(2, 5, 5);
    comparados++;
    if (ocupado_s !== 1'b1) begin fallos++; $display("FAIL ocupado_inicio: got %b want 1", ocupado_s); end
    esperar(lat, sin_oc);
    comparados++;
    if (lat !== 10) begin fallos++; $display("FAIL latencia_255: got %0d want 10", lat); end
    comparados++;
    if (sin_oc !== 0) begin fallos++; $display("FAIL ocupado_255: low for %0d cycles want 0", sin_oc); end
    comparados++;
    if ({salida_s, error_s, desborde_s, ocupado_s} !== {8'hFF, 3'b000}) begin
      fallos++; $display("FAIL salida_255: got %h/%b/%b/%b want ff/0/0/0", salida_s, error_s, desborde_s, ocupado_s);
    end
    @(posedge clk); #1;
    comparados++;
    if (listo_s !== 1'b0) begin fallos++; $display("FAIL listo_pulso: got %b want 0", listo_s); end
  endtask

  task automatic test_barrido();
    int lat, sin_oc;
    logic [7:0] es; logic ee, eo;
    for (int v = 0; v < 256; v++) begin
      lanzar(v / 100, (v / 10) % 10, v % 10);
      esperar(lat, sin_oc);
      modelo(v / 100, (v / 10) % 10, v % 10, 1'b1, es, ee, eo);
      comparados++;
      if (lat !== 10 || {salida_s, error_s, desborde_s} !== {es, ee, eo}) begin
        fallos++;
        $display("FAIL barrido_sat %0d: lat %0d out %h/%b/%b want 10 %h/%b/%b", v, lat,
                 salida_s, error_s, desborde_s, es, ee, eo);
      end
      comparados++;
      if ({salida_n, error_n, desborde_n} !== {8'(v), 2'b00}) begin
        fallos++;
        $display("FAIL barrido_nosat %0d: got %h/%b/%b want %h/0/0", v, salida_n, error_n, desborde_n, 8'(v));
      end
    end
  endtask

  task automatic test_aleatorio();
    int lat, sin_oc, c, d, u, lat_esp;
    logic [7:0] es_s, es_n; logic ee, eo;
    for (int n = 0; n < 60; n++) begin
      c = $urandom_range(0, 9); d = $urandom_range(0, 9); u = $urandom_range(0, 9);
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0: c = $urandom_range(10, 15);
          1: d = $urandom_range(10, 15);
          default: u = $urandom_range(10, 15);
        endcase
      end
      lanzar(c, d, u);
      esperar(lat, sin_oc);
      modelo(c, d, u, 1'b1, es_s, ee, eo);
      modelo(c, d, u, 1'b0, es_n, ee, eo);
      lat_esp = ee ? 1 : 10;
      comparados++;
      if (lat !== lat_esp || {salida_s, error_s, desborde_s} !== {es_s, ee, eo}
          || {salida_n, error_n, desborde_n, listo_n} !== {es_n, ee, eo, 1'b1}) begin
        fallos++;
        $display("FAIL aleatorio %0d%0d%0d: lat %0d sat %h/%b/%b nosat %h/%b/%b want lat %0d sat %h nosat %h e%b o%b",
                 c, d, u, lat, salida_s, error_s, desborde_s, salida_n, error_n, desborde_n,
                 lat_esp, es_s, es_n, ee, eo);
      end
    end
  endtask

  task automatic test_desborde();
    int lat, sin_oc;
    int c [2] = '{2, 9};
    int d [2] = '{5, 9};
    int u [2] = '{6, 9};
    logic [7:0] nosat_esp [2] = '{8'h00, 8'hE7};
    for (int i = 0; i < 2; i++) begin
      lanzar(c[i], d[i], u[i]);
      esperar(lat, sin_oc);
      comparados++;
      if (lat !== 10 || {salida_s, desborde_s, error_s} !== {8'hFF, 2'b10}) begin
        fallos++;
        $display("FAIL desborde_sat %0d: lat %0d got %h/%b/%b want ff/1/0", i, lat, salida_s, desborde_s, error_s);
      end
      comparados++;
      if ({salida_n, desborde_n, error_n} !== {nosat_esp[i], 2'b10}) begin
        fallos++;
        $display("FAIL desborde_nosat %0d: got %h/%b/%b want %h/1/0", i, salida_n, desborde_n, error_n, nosat_esp[i]);
      end
    end
  endtask

  task automatic test_invalido();
    int lat, sin_oc;
    lanzar(1, 10, 3);
    esperar(lat, sin_oc);
    comparados++;
    if (lat !== 1 || {salida_s, error_s, desborde_s, ocupado_s} !== {8'h00, 3'b100}) begin
      fallos++;
      $display("FAIL invalido: lat %0d got %h/%b/%b/%b want 1 00/1/0/0", lat, salida_s, error_s, desborde_s, ocupado_s);
    end
    lanzar(0, 4, 2);
    comparados++;
    if (error_s !== 1'b0) begin fallos++; $display("FAIL error_borrado: got %b want 0", error_s); end
    esperar(lat, sin_oc);
    comparados++;
    if (lat !== 10 || {salida_s, error_s, desborde_s} !== {8'h2A, 2'b00}) begin
      fallos++;
      $display("FAIL tras_invalido: lat %0d got %h/%b/%b want 10 2a/0/0", lat, salida_s, error_s, desborde_s);
    end
  endtask

  task automatic test_back_to_back();
    int lat, sin_oc, c, d, u;
    logic [7:0] es; logic ee, eo;
    lanzar(1, 2, 3);
    repeat (3) @(posedge clk); #1;
    centena = 4'd0; decena = 4'd0; unidad = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    esperar(lat, sin_oc);
    comparados++;
    if (lat !== 6 || salida_s !== 8'h7B) begin
      fallos++; $display("FAIL ignorado: lat %0d salida %h want 6 7b", lat, salida_s);
    end
    c = $urandom_range(0, 9); d = $urandom_range(0, 9); u = $urandom_range(0, 9);
    lanzar(c, d, u);
    comparados++;
    if (ocupado_s !== 1'b1) begin fallos++; $display("FAIL aceptado_en_listo: ocupado %b want 1", ocupado_s); end
    esperar(lat, sin_oc);
    modelo(c, d, u, 1'b1, es, ee, eo);
    comparados++;
    if (lat !== 10 || {salida_s, error_s, desborde_s} !== {es, ee, eo}) begin
      fallos++;
      $display("FAIL back_to_back %0d%0d%0d: lat %0d got %h/%b/%b want 10 %h/%b/%b",
               c, d, u, lat, salida_s, error_s, desborde_s, es, ee, eo);
    end
  endtask

  task automatic test_reset_medio();
    int lat, sin_oc, vistos;
    lanzar(1, 2, 3);
    repeat (4) @(posedge clk);
    @(posedge clk);
    rst = 1'b1;
    #1;
    comparados++;
    if ({salida_s, listo_s, ocupado_s, error_s, desborde_s} !== 12'h0) begin
      fallos++;
      $display("FAIL reset_medio: got %h want 0", {salida_s, listo_s, ocupado_s, error_s, desborde_s});
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    vistos = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (listo_s || ocupado_s) vistos++;
    end
    comparados++;
    if (vistos !== 0) begin fallos++; $display("FAIL reset_sin_listo: %0d active cycles want 0", vistos); end
    lanzar(0, 4, 2);
    esperar(lat, sin_oc);
    comparados++;
    if (lat !== 10 || {salida_s, error_s, desborde_s} !== {8'h2A, 2'b00}) begin
      fallos++;
      $display("FAIL tras_reset: lat %0d got %h/%b/%b want 10 2a/0/0", lat, salida_s, error_s, desborde_s);
    end
  endtask

  initial begin
    test_reset();
    test_255();
    test_barrido();
    test_aleatorio();
    test_desborde();
    test_invalido();
    test_back_to_back();
    test_reset_medio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, fallos);
    $finish;
  end

endmodule
